// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port, registered-output framebuffer RAM between VGA
//   scan-out and a CPU bus. A visible pixel strobe always owns the RAM for
//   that clock. The CPU gets every other clock, with at most one access
//   outstanding. Pixel and CPU read data come back through a one-stage tag
//   pipe that matches the one-clock RAM read latency, so results appear two
//   clocks after the slot that issued them.
//
// Ports
//   clk, reset                   system clock, synchronous active-high reset
//   pixel_strobe, active         pixel enable / visible flag from vga_generator
//   mode, x, y                   0 = 640 wide, 1 = 320 wide; pixel coordinates
//   cpu_req/we/addr/wdata        CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata           1-clk completion pulse, read data (held)
//   ram_addr/we/wdata            RAM command (combinational)
//   ram_rdata                    RAM read data, valid 1 clk after address
//   pix_data, pix_valid          pixel to DAC, 1-clk update pulse
module vga_fb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int H_RES_LO = 320
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_strobe,
  input  logic              active,
  input  logic              mode,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam logic [31:0] W_LO = 32'(H_RES_LO);

  logic [ADDR_W-1:0] y_ext, x_ext, row_lo, pix_addr;
  logic              vga_slot, blank_slot, cpu_go;

  logic              vga_tag_q, vga_tag_d;
  logic              blank_tag_q, blank_tag_d;
  logic              rd_tag_q, rd_tag_d;
  logic              busy_q, busy_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;

  // y*W + x built from shifted copies of y for each set bit of the constant
  // line width; mode=0 doubles the row offset with a single left shift.
  always_comb begin
    y_ext  = ADDR_W'(y);
    x_ext  = ADDR_W'(x);
    row_lo = '0;
    for (int i = 0; i < 32; i++) begin
      if (W_LO[i]) row_lo = row_lo + (y_ext << i);
    end
    pix_addr = (mode ? row_lo : {row_lo[ADDR_W-2:0], 1'b0}) + x_ext;
  end

  // Slot decision and RAM command. busy covers the whole access including
  // the ack clock; cpu_ack_q is kept in the term so a held request can never
  // be taken again in the clock it is acknowledged.
  always_comb begin
    vga_slot    = pixel_strobe & active;
    blank_slot  = pixel_strobe & ~active;
    cpu_go      = ~reset & ~vga_slot & cpu_req & ~busy_q & ~cpu_ack_q;
    ram_addr    = '0;
    ram_we      = 1'b0;
    vga_tag_d   = 1'b0;
    rd_tag_d    = 1'b0;
    blank_tag_d = blank_slot;
    if (vga_slot) begin
      ram_addr  = pix_addr;
      vga_tag_d = 1'b1;
    end else if (cpu_go) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      rd_tag_d = ~cpu_we;
    end
  end

  assign ram_wdata = cpu_wdata;

  // Results: the tags registered at the end of the slot clock mark what the
  // RAM is returning during the following clock.
  always_comb begin
    busy_d = busy_q;
    if (cpu_go)    busy_d = 1'b1;
    if (cpu_ack_q) busy_d = 1'b0;
    cpu_ack_d   = (cpu_go & cpu_we) | rd_tag_q;
    cpu_rdata_d = rd_tag_q ? ram_rdata : cpu_rdata_q;
    pix_valid_d = vga_tag_q | blank_tag_q;
    pix_data_d  = pix_data_q;
    if (vga_tag_q)        pix_data_d = ram_rdata;
    else if (blank_tag_q) pix_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_tag_q   <= 1'b0;
      blank_tag_q <= 1'b0;
      rd_tag_q    <= 1'b0;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      vga_tag_q   <= vga_tag_d;
      blank_tag_q <= blank_tag_d;
      rd_tag_q    <= rd_tag_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int DW = 8;
  localparam int AW = 17;
  localparam int MEMSZ = 1 << AW;
  localparam int NS = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_strobe = 1'b0, active = 1'b0, mode = 1'b0;
  logic [9:0]    x = '0;
  logic [8:0]    y = '0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, ram_we, pix_valid;
  logic [DW-1:0] cpu_rdata, ram_wdata, pix_data;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .H_RES_LO(320)) dut (
    .clk(clk), .reset(reset), .pixel_strobe(pixel_strobe), .active(active),
    .mode(mode), .x(x), .y(y), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pix_data(pix_data),
    .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM (environment) and the model's own copy of its contents.
  logic [DW-1:0] ram  [MEMSZ];
  logic [DW-1:0] mmem [MEMSZ];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: events are scheduled by cycle number from the access
  // rules (result two clocks after a read/pixel slot, one after a write).
  logic          s_pv [NS];
  logic [DW-1:0] s_pd [NS];
  logic          s_ack [NS];
  logic          s_rdv [NS];
  logic [DW-1:0] s_rd [NS];
  int            n = 0;
  int            cpu_free = 0;
  logic          rst_prev = 1'b1;
  logic [DW-1:0] m_pix = '0, m_rd = '0;

  always @(negedge clk) begin
    int  pa, ea;
    logic vga, acc;
    if (rst_prev) begin
      m_pix = '0; m_rd = '0;
      s_pv[n] = 0; s_ack[n] = 0; s_rdv[n] = 0;
    end
    if (s_pv[n]) m_pix = s_pd[n];
    if (s_rdv[n]) m_rd = s_rd[n];
    check("m_pix_valid", int'(pix_valid), int'(s_pv[n]));
    check("m_pix_data", int'(pix_data), int'(m_pix));
    check("m_cpu_ack", int'(cpu_ack), int'(s_ack[n]));
    check("m_cpu_rdata", int'(cpu_rdata), int'(m_rd));
    if (reset) begin
      cpu_free = 0;
      check("m_ram_we_rst", int'(ram_we), 0);
    end else begin
      pa  = (int'(y) * (mode ? 320 : 640) + int'(x)) % MEMSZ;
      vga = pixel_strobe && active;
      acc = !vga && cpu_req && (n >= cpu_free);
      ea  = vga ? pa : (acc ? int'(cpu_addr) : 0);
      check("m_ram_addr", int'(ram_addr), ea);
      check("m_ram_we", int'(ram_we), int'(acc && cpu_we));
      if (ram_we) check("m_ram_wdata", int'(ram_wdata), int'(cpu_wdata));
      if (pixel_strobe) begin
        s_pv[n+2] = 1;
        s_pd[n+2] = active ? mmem[pa] : '0;
      end
      if (acc) begin
        if (cpu_we) begin
          mmem[cpu_addr] = cpu_wdata;
          s_ack[n+1] = 1;
          cpu_free = n + 2;
        end else begin
          s_ack[n+2] = 1; s_rdv[n+2] = 1; s_rd[n+2] = mmem[cpu_addr];
          cpu_free = n + 3;
        end
      end
    end
    rst_prev = reset;
    n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin_wait();
    #3;
  endtask

  initial begin
    bit got_ack;
    for (int i = 0; i < MEMSZ; i++) begin
      ram[i] = DW'(i * 7 + 1);
      mmem[i] = DW'(i * 7 + 1);
    end
    ram[645] = 8'hA5;    mmem[645] = 8'hA5;
    ram[45055] = 8'h5A;  mmem[45055] = 8'h5A;
    ram[17'h200] = 8'hC3; mmem[17'h200] = 8'hC3;
    for (int i = 0; i < NS; i++) begin
      s_pv[i] = 0; s_pd[i] = '0; s_ack[i] = 0; s_rdv[i] = 0; s_rd[i] = '0;
    end

    // Reset with a pending request
    cpu_req = 1; cpu_we = 1; cpu_addr = 17'h7; cpu_wdata = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick(); pin_wait();
      check("rst_no_ack", int'(cpu_ack), 0);
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_pix_data", int'(pix_data), 0);
    end
    tick(); reset = 0; cpu_req = 0; cpu_we = 0;

    // Pixel fetch, mode=1
    tick(); mode = 1; x = 10'd5; y = 9'd2; pixel_strobe = 1; active = 1;
    pin_wait(); check("pix_addr_645", int'(ram_addr), 645);
    tick(); pixel_strobe = 0;
    tick(); pin_wait();
    check("pix_valid_t2", int'(pix_valid), 1);
    check("pix_data_a5", int'(pix_data), 8'hA5);
    tick();

    // CPU write on idle bus, request held through ack
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00100; cpu_wdata = 8'h3C;
    pin_wait(); check("wr_ram_we", int'(ram_we), 1);
    check("wr_ram_addr", int'(ram_addr), 17'h100);
    tick(); pin_wait();
    check("wr_ack", int'(cpu_ack), 1);
    check("wr_no_reaccept", int'(ram_we), 0);
    tick(); cpu_req = 0; pin_wait();
    check("wr_ack_pulse", int'(cpu_ack), 0);

    // CPU read colliding with a VGA strobe
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00100;
    pixel_strobe = 1; active = 1; x = 10'd5; y = 9'd2; mode = 1;
    pin_wait(); check("coll_vga_first", int'(ram_addr), 645);
    tick(); pixel_strobe = 0; pin_wait();
    check("coll_cpu_next", int'(ram_addr), 17'h100);
    tick(); pin_wait();
    check("coll_pix", int'(pix_data), 8'hA5);
    tick(); pin_wait();
    check("coll_ack", int'(cpu_ack), 1);
    check("coll_rdata", int'(cpu_rdata), 8'h3C);
    tick(); cpu_req = 0;

    // mode=0 corner pixel, then blanking strobe serving the CPU
    tick(); mode = 0; x = 10'd639; y = 9'd479; pixel_strobe = 1; active = 1;
    pin_wait(); check("pix_addr_wrap", int'(ram_addr), 45055);
    tick(); pixel_strobe = 0;
    tick(); pin_wait(); check("pix_data_5a", int'(pix_data), 8'h5A);
    tick(); pixel_strobe = 1; active = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 17'h200;
    pin_wait(); check("blank_cpu_addr", int'(ram_addr), 17'h200);
    tick(); pixel_strobe = 0;
    tick(); pin_wait();
    check("blank_valid", int'(pix_valid), 1);
    check("blank_zero", int'(pix_data), 0);
    check("blank_ack", int'(cpu_ack), 1);
    check("blank_rdata", int'(cpu_rdata), 8'hC3);
    tick(); cpu_req = 0;

    // Reset right after a read issue drops the access
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 17'h100;
    pin_wait(); check("abort_issue", int'(ram_addr), 17'h100);
    tick(); reset = 1; cpu_req = 0;
    tick(); reset = 0; pin_wait();
    check("abort_no_ack", int'(cpu_ack), 0);
    tick(); pin_wait(); check("abort_no_ack2", int'(cpu_ack), 0);
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 17'h200;
    got_ack = 0;
    for (int i = 0; i < 6 && !got_ack; i++) begin
      tick(); pin_wait();
      got_ack = cpu_ack;
    end
    check("after_rst_ack", int'(got_ack), 1);
    check("after_rst_rdata", int'(cpu_rdata), 8'hC3);
    tick(); cpu_req = 0;

    // Mixed traffic: strobe every 3 clk, periodic blanking, CPU master
    got_ack = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      pixel_strobe = (i % 3 == 0);
      active = (i % 9 != 6);
      mode = i[4];
      x = 10'(i * 3);
      y = 9'(i / 3);
      if (got_ack) cpu_req = 0;
      else if (!cpu_req && (i % 4 == 1)) begin
        cpu_req = 1;
        cpu_we = i[1] ^ i[3];
        cpu_addr = 17'(17'h100 + (i % 5));
        cpu_wdata = 8'(i * 13);
      end
      pin_wait();
      got_ack = cpu_ack;
    end
    tick(); cpu_req = 0; pixel_strobe = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

endmodule
